// File: rtl/burst_rr_arbiter.sv
// Burst-limited round-robin merger of WIDTH FWFT source FIFOs into one output FIFO.
// Adds per-source enable, record locking via HOLD_REQ with timeout, and a word counter.
module burst_rr_arbiter #(
    parameter int WIDTH        = 8,
    parameter int DATA_BITS    = 32,
    parameter int HOLD_TIMEOUT = 255
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic [WIDTH-1:0]           WRITE_REQ,
    input  logic [WIDTH-1:0]           HOLD_REQ,
    input  logic [WIDTH*DATA_BITS-1:0] DATA_IN,
    output logic [WIDTH-1:0]           READ_GRANT,
    input  logic [WIDTH-1:0]           SRC_ENABLE,
    input  logic [7:0]                 BURST_LIMIT,
    input  logic                       CNT_CLR,
    input  logic                       READY_OUT,
    output logic                       WRITE_OUT,
    output logic [DATA_BITS-1:0]       DATA_OUT,
    output logic [3:0]                 GRANT_ID,
    output logic                       BUSY,
    output logic                       HOLD_TO_ERR,
    output logic [31:0]                WORD_COUNT
);

    // state  | meaning
    // IDLE   | pick next enabled requester after last_id; no word moves
    // GRANT  | GRANT_ID owns the output until release
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]           state;
    logic [3:0]           last_id;
    logic [7:0]           burst_cnt;
    logic [7:0]           hold_cnt;

    logic [WIDTH-1:0]     cand;
    logic [WIDTH-1:0]     gnt_mask;
    logic                 any_cand;
    logic                 hi_found;
    logic [3:0]           lo_id;
    logic [3:0]           hi_id;
    logic [3:0]           next_id;
    logic                 cur_req;
    logic                 cur_hold;
    logic                 cur_en;
    logic [DATA_BITS-1:0] cur_data;
    logic [7:0]           burst_inc;
    logic [7:0]           hold_inc;
    logic                 xfer;
    logic                 hold_wait;
    logic                 timeout;
    logic                 release_now;

    // Lowest candidate above last_id wins; otherwise wrap to the lowest candidate overall.
    always_comb begin
        cand     = WRITE_REQ & SRC_ENABLE;
        any_cand = 1'b0;
        hi_found = 1'b0;
        lo_id    = '0;
        hi_id    = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (cand[i]) begin
                any_cand = 1'b1;
                lo_id    = 4'(i);
                if (4'(i) > last_id) begin
                    hi_found = 1'b1;
                    hi_id    = 4'(i);
                end
            end
        end
        next_id = hi_found ? hi_id : lo_id;
    end

    always_comb begin
        gnt_mask = '0;
        cur_data = '0;
        for (int i = 0; i < WIDTH; i++) begin
            gnt_mask[i] = (GRANT_ID == 4'(i));
            if (gnt_mask[i]) begin
                cur_data = DATA_IN[i*DATA_BITS +: DATA_BITS];
            end
        end
        cur_req  = |(WRITE_REQ & gnt_mask);
        cur_hold = |(HOLD_REQ & gnt_mask);
        cur_en   = |(SRC_ENABLE & gnt_mask);
    end

    // A held record keeps flowing even if its source gets disabled mid-record.
    always_comb begin
        burst_inc   = (burst_cnt == 8'hFF) ? burst_cnt : burst_cnt + 8'd1;
        hold_inc    = hold_cnt + 8'd1;
        xfer        = (state == ST_GRANT) && READY_OUT && cur_req && (cur_hold || cur_en);
        hold_wait   = (state == ST_GRANT) && READY_OUT && cur_hold && !cur_req;
        timeout     = hold_wait && (hold_inc == 8'(HOLD_TIMEOUT));
        release_now = 1'b0;
        if (state == ST_GRANT) begin
            if (cur_hold) begin
                release_now = timeout;
            end else begin
                release_now = !cur_req
                            || (READY_OUT && !cur_en)
                            || (xfer && (BURST_LIMIT != 8'd0) && (burst_inc == BURST_LIMIT));
            end
        end
        READ_GRANT = xfer ? gnt_mask : '0;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state       <= ST_IDLE;
            last_id     <= 4'(WIDTH - 1);
            GRANT_ID    <= '0;
            burst_cnt   <= '0;
            hold_cnt    <= '0;
            WRITE_OUT   <= 1'b0;
            DATA_OUT    <= '0;
            HOLD_TO_ERR <= 1'b0;
            WORD_COUNT  <= '0;
        end else begin
            WRITE_OUT <= xfer;
            if (xfer) begin
                DATA_OUT <= cur_data;
            end
            if (CNT_CLR) begin
                WORD_COUNT <= '0;
            end else if (WRITE_OUT) begin
                WORD_COUNT <= WORD_COUNT + 32'd1;
            end
            if (timeout) begin
                HOLD_TO_ERR <= 1'b1;
            end else if (CNT_CLR) begin
                HOLD_TO_ERR <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (any_cand) begin
                        GRANT_ID  <= next_id;
                        burst_cnt <= '0;
                        hold_cnt  <= '0;
                        state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (xfer) begin
                        burst_cnt <= burst_inc;
                        hold_cnt  <= '0;
                    end else if (hold_wait) begin
                        hold_cnt <= hold_inc;
                    end
                    if (release_now) begin
                        state   <= ST_IDLE;
                        last_id <= GRANT_ID;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign BUSY = (state == ST_GRANT);

endmodule

// File: tb/tb_burst_rr_arbiter.sv
// Randomized and directed bench for burst_rr_arbiter against a queue-based reference model.
module tb_burst_rr_arbiter;
    localparam int W  = 8;
    localparam int DB = 32;
    localparam int HOLD_TIMEOUT = 255;

    logic            clk = 1'b0;
    logic            n_rst;
    logic [W-1:0]    write_req, hold_req, src_enable, read_grant;
    logic [W*DB-1:0] data_in;
    logic [7:0]      burst_limit;
    logic            cnt_clr, ready_out, write_out, busy, hold_to_err;
    logic [DB-1:0]   data_out;
    logic [3:0]      grant_id;
    logic [31:0]     word_count;

    burst_rr_arbiter #(.WIDTH(W), .DATA_BITS(DB), .HOLD_TIMEOUT(HOLD_TIMEOUT)) dut (
        .CLK(clk), .nRST(n_rst), .WRITE_REQ(write_req), .HOLD_REQ(hold_req),
        .DATA_IN(data_in), .READ_GRANT(read_grant), .SRC_ENABLE(src_enable),
        .BURST_LIMIT(burst_limit), .CNT_CLR(cnt_clr), .READY_OUT(ready_out),
        .WRITE_OUT(write_out), .DATA_OUT(data_out), .GRANT_ID(grant_id),
        .BUSY(busy), .HOLD_TO_ERR(hold_to_err), .WORD_COUNT(word_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // stimulus state
    logic [31:0] srcq [W][$];
    int          seqn [W];
    logic [31:0] out_log [$];
    int          grant_log [$];
    logic [W-1:0] refill_mask = '0;

    // reference model state
    bit          m_busy, m_wo, m_err;
    int          m_id, m_last, m_burst, m_hold;
    logic [31:0] m_do, m_cnt;
    logic [W-1:0] e_rg;
    bit          e_xfer, e_rel, e_to, e_any;
    int          e_pick;
    logic [31:0] e_data;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic push(input int s, input int n);
        for (int k = 0; k < n; k++) begin
            srcq[s].push_back({8'(s), 24'(seqn[s])});
            seqn[s]++;
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < W; i++) begin
            if (refill_mask[i] && srcq[i].size() < 2) push(i, 2);
            write_req[i] = (srcq[i].size() > 0);
            if (write_req[i]) data_in[i*DB +: DB] = srcq[i][0];
            else              data_in[i*DB +: DB] = 32'hEE00_0000 | 32'(i);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    task automatic model_comb();
        bit req, hld, en;
        int idx;
        e_rg = '0; e_xfer = 0; e_rel = 0; e_to = 0; e_any = 0; e_pick = 0; e_data = '0;
        if (m_busy) begin
            req = write_req[m_id];
            hld = hold_req[m_id];
            en  = src_enable[m_id];
            e_xfer = ready_out && req && (hld || en);
            if (e_xfer) begin
                e_rg[m_id] = 1'b1;
                e_data = srcq[m_id][0];
            end
            if (hld) begin
                e_to  = !req && ready_out && (m_hold + 1 == HOLD_TIMEOUT);
                e_rel = e_to;
            end else begin
                e_rel = !req || (ready_out && !en)
                     || (e_xfer && burst_limit != 0 && sat_inc(m_burst) == int'(burst_limit));
            end
        end else begin
            for (int k = 1; k <= W; k++) begin
                idx = (m_last + k) % W;
                if (!e_any && write_req[idx] && src_enable[idx]) begin
                    e_any = 1;
                    e_pick = idx;
                end
            end
        end
    endtask

    task automatic model_seq();
        if (!n_rst) begin
            m_busy = 0; m_id = 0; m_last = W - 1; m_burst = 0; m_hold = 0;
            m_wo = 0; m_do = '0; m_err = 0; m_cnt = '0;
        end else begin
            if (cnt_clr) m_cnt = '0;
            else if (m_wo) m_cnt = m_cnt + 1;
            if (e_to) m_err = 1;
            else if (cnt_clr) m_err = 0;
            m_wo = e_xfer;
            if (e_xfer) m_do = e_data;
            if (!m_busy) begin
                if (e_any) begin
                    m_busy = 1; m_id = e_pick; m_burst = 0; m_hold = 0;
                end
            end else begin
                if (e_xfer) begin
                    m_burst = sat_inc(m_burst);
                    m_hold = 0;
                end else if (hold_req[m_id] && !write_req[m_id] && ready_out) begin
                    m_hold++;
                end
                if (e_rel) begin
                    m_busy = 0;
                    m_last = m_id;
                end
            end
        end
    endtask

    // One clock: drive at negedge, check combinational grant, then registered outputs after the edge.
    task automatic cycle();
        logic [W-1:0] rg_s;
        drive_inputs();
        #1;
        model_comb();
        rg_s = read_grant;
        check_eq("read_grant", 32'(rg_s), 32'(e_rg));
        @(posedge clk);
        model_seq();
        for (int i = 0; i < W; i++) begin
            if (rg_s[i]) begin
                grant_log.push_back(i);
                if (srcq[i].size() > 0) void'(srcq[i].pop_front());
            end
        end
        #1;
        check_eq("write_out", 32'(write_out), 32'(m_wo));
        check_eq("data_out", data_out, m_do);
        check_eq("busy", 32'(busy), 32'(m_busy));
        if (m_busy) check_eq("grant_id", 32'(grant_id), 32'(m_id));
        check_eq("hold_to_err", 32'(hold_to_err), 32'(m_err));
        check_eq("word_count", word_count, m_cnt);
        if (write_out) out_log.push_back(data_out);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    int cnt0;

    initial begin
        for (int i = 0; i < W; i++) seqn[i] = 0;
        n_rst = 1'b0; hold_req = '0; src_enable = '1; burst_limit = 8'd0;
        cnt_clr = 1'b0; ready_out = 1'b1; write_req = '0; data_in = '0;
        @(negedge clk);

        // reset state
        run(3);
        check_eq("rst_word_count", word_count, 32'd0);
        check_eq("rst_data_out", data_out, 32'd0);
        n_rst = 1'b1;

        // sources 0, 2, 5 with three words each, unlimited bursts
        out_log.delete();
        push(0, 3); push(2, 3); push(5, 3);
        run(20);
        check_eq("s1_count", 32'(out_log.size()), 32'd9);
        for (int k = 0; k < out_log.size() && k < 9; k++)
            check_eq("s1_order", out_log[k], {8'((k / 3) == 0 ? 0 : (k / 3) == 1 ? 2 : 5), 24'(k % 3)});
        check_eq("s1_word_count", word_count, 32'd9);

        // burst limit 2, sources 1 and 3 always busy
        burst_limit = 8'd2;
        grant_log.delete();
        refill_mask = 8'b0000_1010;
        run(30);
        refill_mask = '0;
        check_eq("s2_len", 32'(grant_log.size() >= 12), 32'd1);
        for (int k = 0; k < 12 && k < grant_log.size(); k++)
            check_eq("s2_alternate", 32'(grant_log[k]), 32'(((k / 2) % 2 == 0) ? 1 : 3));
        run(12);

        // held-but-empty source 4 times out, then source 6 goes
        burst_limit = 8'd0;
        grant_log.delete();
        push(4, 1); push(6, 2);
        hold_req[4] = 1'b1;
        run(300);
        check_eq("s3_first", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd4);
        check_eq("s3_next", 32'(grant_log.size() > 1 ? grant_log[1] : -1), 32'd6);
        check_eq("s3_err", 32'(hold_to_err), 32'd1);
        hold_req = '0;
        cnt_clr = 1'b1;
        run(1);
        cnt_clr = 1'b0;
        check_eq("s3_err_clr", 32'(hold_to_err), 32'd0);

        // ready toggling during a 4-word burst
        out_log.delete();
        push(2, 4);
        for (int k = 0; k < 14; k++) begin
            ready_out = (k % 2 == 0);
            cycle();
        end
        ready_out = 1'b1;
        check_eq("s4_count", 32'(out_log.size()), 32'd4);
        for (int k = 0; k < out_log.size() && k < 4; k++)
            check_eq("s4_data", out_log[k], {8'd2, 24'(3 + k)});

        // disabled source 0 is skipped, later re-enabled
        grant_log.delete();
        src_enable[0] = 1'b0;
        push(0, 3); push(1, 2); push(7, 2);
        run(20);
        cnt0 = 0;
        foreach (grant_log[k]) if (grant_log[k] == 0) cnt0++;
        check_eq("s5_no_src0", 32'(cnt0), 32'd0);
        check_eq("s5_others", 32'(grant_log.size()), 32'd4);
        src_enable[0] = 1'b1;
        grant_log.delete();
        run(15);
        check_eq("s5_src0_after", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd0);

        // reset mid-burst
        push(3, 6);
        run(3);
        n_rst = 1'b0;
        run(1);
        check_eq("s6_busy", 32'(busy), 32'd0);
        check_eq("s6_write_out", 32'(write_out), 32'd0);
        n_rst = 1'b1;
        grant_log.delete();
        push(0, 2);
        run(12);
        check_eq("s6_src0_first", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < W; i++)
                if ($urandom_range(7) == 0 && srcq[i].size() < 8) push(i, $urandom_range(1, 4));
            ready_out = ($urandom_range(3) != 0);
            if ($urandom_range(31) == 0) src_enable[$urandom_range(W - 1)] ^= 1'b1;
            if ($urandom_range(15) == 0) hold_req[$urandom_range(W - 1)] ^= 1'b1;
            if (c % 64 == 0) begin
                case ($urandom_range(5))
                    0: burst_limit = 8'd0;
                    1: burst_limit = 8'd1;
                    2: burst_limit = 8'd2;
                    3: burst_limit = 8'd3;
                    4: burst_limit = 8'd5;
                    default: burst_limit = 8'd255;
                endcase
            end
            cnt_clr = ($urandom_range(63) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
